// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM state enum,
// channel-count ceiling and the round-robin winner search.
package edge_arb_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } arb_state_t;

    // Scans ptr+1 .. ptr (mod n_ch) and returns the first requesting index.
    // Walking the offsets from far to near means the last hit is the nearest one.
    function automatic int rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n_ch);
        int win;
        int idx;
        win = ptr;
        for (int k = MAX_CH; k >= 1; k--) begin
            idx = ptr + k;
            if (idx >= n_ch) idx = idx - n_ch;
            if (k <= n_ch && req[idx[3:0]]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rise_det.sv
// Single-channel rising-edge detector: two sampling flops, rise = s0 & ~s1.
module edge_rise_det (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic s0;
    logic s1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= d;
            s1 <= s0;
        end
    end

    assign rise = s0 & ~s1;

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin valid/ready event port.
// Optional sticky overflow flags are built when EDGE_ARB_OVF_EN is defined.
//
// state    | meaning
// ST_IDLE  | nothing offered; picks a round-robin winner when any flag is pending
// ST_OFFER | evt_id offered with evt_valid=1, held until evt_ready
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] din,
    input  logic            evt_ready,
`ifdef EDGE_ARB_OVF_EN
    input  logic            ovf_clr,
    output logic [N_CH-1:0] ovf,
`endif
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_id,
    output logic [N_CH-1:0] pending
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [CH_W-1:0] id_nxt;
    logic [CH_W-1:0] ptr;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] clr;
    logic            accept;

    for (genvar i = 0; i < N_CH; i++) begin : g_det
        edge_rise_det u_det (
            .clk    (clk),
            .resetn (resetn),
            .d      (din[i]),
            .rise   (rise[i])
        );
    end

    assign evt_valid = (state == ST_OFFER);
    assign accept    = evt_valid & evt_ready;
    assign clr       = accept ? (N_CH'(1) << evt_id) : '0;

    always_comb begin
        state_nxt = state;
        id_nxt    = evt_id;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    id_nxt    = CH_W'(rr_next(MAX_CH'(pending), int'(ptr), N_CH));
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            evt_id  <= '0;
            ptr     <= CH_W'(N_CH - 1);
            pending <= '0;
        end else begin
            state   <= state_nxt;
            evt_id  <= id_nxt;
            if (accept) ptr <= evt_id;
            // A rise on the channel being accepted re-arms it as a fresh event.
            pending <= (pending & ~clr) | rise;
        end
    end

`ifdef EDGE_ARB_OVF_EN
    logic [N_CH-1:0] ovf_set;

    assign ovf_set = rise & pending & ~clr;

    // Set beats a simultaneous clear for the same bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf_clr ? '0 : ovf) | ovf_set;
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter (N_CH=4): directed scenarios plus
// randomized traffic compared against an event-level reference model.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] din = '0;
    logic         evt_ready = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [N-1:0] pending;
`ifdef EDGE_ARB_OVF_EN
    logic         ovf_clr = 1'b0;
    logic [N-1:0] ovf;
`endif

    int n_checks = 0;
    int n_pass = 0;

    edge_event_arbiter #(.N_CH(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .evt_ready (evt_ready),
`ifdef EDGE_ARB_OVF_EN
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
`endif
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Reference model: sample history, pending set, currently offered channel
    // (-1 when none), last served channel and sticky merge flags.
    bit [N-1:0] h0, h1, m_pend, m_ovf;
    int m_offer = -1;
    int m_last = N - 1;
    int m_id = 0;

    always @(posedge clk) begin : model
        int acc;
        int nxt;
        int c;
        bit [N-1:0] np;
        bit [N-1:0] no;
        if (!resetn) begin
            h0 = '0; h1 = '0; m_pend = '0; m_ovf = '0;
            m_offer = -1; m_last = N - 1; m_id = 0;
        end else begin
            acc = (m_offer >= 0 && evt_ready) ? m_offer : -1;
            nxt = m_offer;
            if (m_offer < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (nxt < 0 && m_pend[c]) nxt = c;
                end
                if (nxt >= 0) m_id = nxt;
            end else if (acc >= 0) begin
                nxt = -1;
                m_last = acc;
            end
            np = m_pend;
            no = m_ovf;
`ifdef EDGE_ARB_OVF_EN
            if (ovf_clr) no = '0;
`endif
            for (int i = 0; i < N; i++) begin
                if (i == acc) np[i] = 1'b0;
                if (h0[i] && !h1[i]) begin
                    if (m_pend[i] && i != acc) no[i] = 1'b1;
                    np[i] = 1'b1;
                end
            end
            m_pend = np; m_ovf = no; m_offer = nxt;
            h1 = h0; h0 = din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        resetn = 1'b0; din = '0; evt_ready = 1'b0;
`ifdef EDGE_ARB_OVF_EN
        ovf_clr = 1'b0;
`endif
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; evt_ready = 1'b0; din = 4'b1111;
        tick(); tick(); tick(); tick();
        resetn = 1'b0;
        tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", evt_valid); else n_pass++;
        n_checks++; if (evt_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", evt_id); else n_pass++;
        n_checks++; if (pending !== 4'b0000) $display("FAIL reset_pending: got %b expected 0000", pending); else n_pass++;
`ifdef EDGE_ARB_OVF_EN
        n_checks++; if (ovf !== 4'b0000) $display("FAIL reset_ovf: got %b expected 0000", ovf); else n_pass++;
`endif
        din = '0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_single_edge();
        reset_dut();
        evt_ready = 1'b1;
        tick(); tick();
        din = 4'b0010;
        tick();
        n_checks++; if (pending !== 4'b0000) $display("FAIL single_pend_n: got %b expected 0000", pending); else n_pass++;
        tick();
        n_checks++; if (pending !== 4'b0010) $display("FAIL single_pend_n1: got %b expected 0010", pending); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL single_valid_n1: got %b expected 0", evt_valid); else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1)
            $display("FAIL single_offer: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b0 || pending !== 4'b0000)
            $display("FAIL single_accept: got valid=%b pend=%b expected valid=0 pend=0000", evt_valid, pending); else n_pass++;
        din = '0;
        tick(); tick();
    endtask

    task automatic test_simultaneous();
        bit ev[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        int ei[8] = '{0, 0, 0, 0, 2, 0, 3, 0};
        reset_dut();
        evt_ready = 1'b1;
        din = 4'b1101;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (evt_valid !== ev[c] || (ev[c] && evt_id !== 2'(ei[c])))
                $display("FAIL simul_cycle%0d: got valid=%b id=%0d expected valid=%b id=%0d",
                         c, evt_valid, evt_id, ev[c], ei[c]);
            else n_pass++;
        end
        n_checks++; if (pending !== 4'b0000) $display("FAIL simul_drain: got %b expected 0000", pending); else n_pass++;
        din = '0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int w = 0;
        reset_dut();
        din = 4'b1000;
        while (evt_valid !== 1'b1 && w < 10) begin tick(); w++; end
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL bp_offer_timeout: got valid=%b expected 1", evt_valid); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd3)
                $display("FAIL bp_hold%0d: got valid=%b id=%0d expected valid=1 id=3", c, evt_valid, evt_id);
            else n_pass++;
        end
        evt_ready = 1'b1;
        tick();
        n_checks++; if (evt_valid !== 1'b0 || pending !== 4'b0000)
            $display("FAIL bp_accept: got valid=%b pend=%b expected valid=0 pend=0000", evt_valid, pending); else n_pass++;
        din = '0; evt_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_merge_overflow();
        int cnt = 0;
        reset_dut();
        din = 4'b0100; tick();
        din = 4'b0000; tick();
        din = 4'b0100; tick();
        din = 4'b0000; tick();
        tick(); tick();
        n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pending !== 4'b0100)
            $display("FAIL merge_offer: got valid=%b id=%0d pend=%b expected valid=1 id=2 pend=0100",
                     evt_valid, evt_id, pending); else n_pass++;
`ifdef EDGE_ARB_OVF_EN
        n_checks++; if (ovf !== 4'b0100) $display("FAIL merge_ovf_set: got %b expected 0100", ovf); else n_pass++;
`endif
        evt_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (evt_valid === 1'b1) cnt++;
            tick();
        end
        n_checks++; if (cnt != 1) $display("FAIL merge_event_count: got %0d expected 1", cnt); else n_pass++;
`ifdef EDGE_ARB_OVF_EN
        n_checks++; if (ovf !== 4'b0100) $display("FAIL merge_ovf_sticky: got %b expected 0100", ovf); else n_pass++;
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_checks++; if (ovf !== 4'b0000) $display("FAIL merge_ovf_clr: got %b expected 0000", ovf); else n_pass++;
`endif
        evt_ready = 1'b0;
        tick();
    endtask

    task automatic test_rearm();
        int w = 0;
        reset_dut();
        din = 4'b0010;
        while (evt_valid !== 1'b1 && w < 10) begin tick(); w++; end
        n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1)
            $display("FAIL rearm_first: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); else n_pass++;
        din = 4'b0000; tick(); tick();
        din = 4'b0010; tick();
        evt_ready = 1'b1; tick();
        n_checks++; if (evt_valid !== 1'b0 || pending !== 4'b0010)
            $display("FAIL rearm_accept: got valid=%b pend=%b expected valid=0 pend=0010", evt_valid, pending); else n_pass++;
`ifdef EDGE_ARB_OVF_EN
        n_checks++; if (ovf !== 4'b0000) $display("FAIL rearm_ovf: got %b expected 0000", ovf); else n_pass++;
`endif
        tick();
        n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1)
            $display("FAIL rearm_second: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b0 || pending !== 4'b0000)
            $display("FAIL rearm_drain: got valid=%b pend=%b expected valid=0 pend=0000", evt_valid, pending); else n_pass++;
        evt_ready = 1'b0; din = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_offer();
        int w = 0;
        int cnt = 0;
        reset_dut();
        din = 4'b0001;
        while (evt_valid !== 1'b1 && w < 10) begin tick(); w++; end
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL rmo_offer_timeout: got valid=%b expected 1", evt_valid); else n_pass++;
        resetn = 1'b0; tick(); resetn = 1'b1;
        n_checks++; if (evt_valid !== 1'b0 || pending !== 4'b0000 || evt_id !== 2'd0)
            $display("FAIL rmo_cleared: got valid=%b pend=%b id=%0d expected valid=0 pend=0000 id=0",
                     evt_valid, pending, evt_id); else n_pass++;
        evt_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (evt_valid === 1'b1 && evt_id === 2'd0) cnt++;
        end
        n_checks++; if (cnt != 1) $display("FAIL rmo_event_count: got %0d expected 1", cnt); else n_pass++;
        din = '0; evt_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            din = din ^ (4'($urandom) & 4'($urandom));
            evt_ready = ($urandom_range(0, 2) != 0);
`ifdef EDGE_ARB_OVF_EN
            ovf_clr = ($urandom_range(0, 15) == 0);
`endif
            tick();
            n_checks++; if (evt_valid !== (m_offer >= 0))
                $display("FAIL rand_valid@%0d: got %b expected %b", c, evt_valid, (m_offer >= 0)); else n_pass++;
            n_checks++; if (evt_id !== 2'(m_id))
                $display("FAIL rand_id@%0d: got %0d expected %0d", c, evt_id, m_id); else n_pass++;
            n_checks++; if (pending !== m_pend)
                $display("FAIL rand_pending@%0d: got %b expected %b", c, pending, m_pend); else n_pass++;
`ifdef EDGE_ARB_OVF_EN
            n_checks++; if (ovf !== m_ovf)
                $display("FAIL rand_ovf@%0d: got %b expected %b", c, ovf, m_ovf); else n_pass++;
`endif
        end
        din = '0; evt_ready = 1'b0;
`ifdef EDGE_ARB_OVF_EN
        ovf_clr = 1'b0;
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_simultaneous();
        test_backpressure();
        test_merge_overflow();
        test_rearm();
        test_reset_mid_offer();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event collector and round-robin scheduler. Each of N_CH single-bit inputs passes through a dedicated rising-edge detector; detected edges latch into per-channel pending flags. A round-robin arbiter serialises the flags onto a single valid/ready event port carrying the channel index. The block sits between the raw status/strobe lines and the single downstream event consumer (interrupt or logging logic).

## Interface
- N_CH, 4, number of input channels; legal range 2..16.
- CH_W, $clog2(N_CH), width of the channel index (derived localparam, not overridable).

- clk  in  1  clock; all state changes on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- din  in  N_CH  raw level inputs, one per channel, synchronous to clk.
- evt_ready  in  1  downstream accepts the offered event.
- evt_valid  out  1  event offered; reset 0.
- evt_id  out  CH_W  channel index of the offered event; reset 0.
- pending  out  N_CH  per-channel pending flags; reset 0.
- ovf_clr  in  1  clears all overflow flags (present only with EDGE_ARB_OVF_EN).
- ovf  out  N_CH  sticky per-channel overflow flags; reset 0 (present only with EDGE_ARB_OVF_EN).

## Operation
- Per channel: registers s0 <= din, s1 <= s0, both reset to 0. rise = s0 & ~s1.
- A din held high through reset release counts as one rising edge (s0=1, s1=0 on the first edge out of reset).
- clr[i] = acceptance of channel i this cycle (state OFFER, evt_ready=1, evt_id=i).
- pending_next = (pending & ~clr) | rise. A rise coinciding with clr on the same channel leaves pending set: a new event.
- Overflow condition: rise[i] & pending[i] & ~clr[i]. The event is merged (dropped).
- FSM, two states:
  - IDLE: evt_valid=0. If any pending bit is set, choose the winner by round robin, load evt_id, set evt_valid=1, go to OFFER. Otherwise stay.
  - OFFER: evt_valid=1, evt_id held stable. If evt_ready: clear pending[evt_id], set ptr=evt_id, drop evt_valid, go to IDLE. Otherwise hold.
- Round robin: search order ptr+1, ptr+2, …, ptr, modulo N_CH with explicit wrap (N_CH need not be a power of two). ptr resets to N_CH-1, so channel 0 has first priority.
- Pending bits of non-offered channels keep accumulating during OFFER.

## Timing
- din sampled high at edge n (previously low): pending set after edge n+1; evt_valid high after edge n+2 if the FSM is IDLE and the channel wins.
- Accept at edge m: evt_valid low after m. Next event offered after edge m+1. Peak throughput is one event per 2 cycles.
- evt_valid must not drop and evt_id must not change while evt_ready=0.
- Reset asserted in any state: after that edge, evt_valid=0, evt_id=0, pending=0, ovf=0, ptr=N_CH-1, state=IDLE. In-flight events are lost.

## Configuration
- EDGE_ARB_OVF_EN defined: ovf register and the ovf/ovf_clr ports exist.
  - ovf[i] is set on the overflow condition.
  - ovf is cleared by ovf_clr=1.
  - If set and clear occur on the same edge, set wins for that bit.
- EDGE_ARB_OVF_EN undefined: no ovf logic or ports. Merged edges are silently dropped. All other behaviour is identical.

## Structure
- Package edge_arb_pkg:
  - FSM state enum (ST_IDLE, ST_OFFER).
  - MAX_CH=16 constant.
  - Round-robin next-index function.
- Sub-module edge_rise_det: one channel's two-flop detector, output rise. Instantiated N_CH times via generate.

## Test plan
- Single edge, ready tied high: din[1] goes 0→1 at edge 10 → evt_valid=1, evt_id=1 after edge 12. Accepted at edge 13. pending=0 after 13.
- Simultaneous edges: din[0], din[2], din[3] rise at the same edge, ready high → ids 0, 2, 3 in order, with evt_valid high every other cycle.
- Backpressure: ready=0 for 5 cycles with an event offered → evt_valid and evt_id stable throughout; accepted on the cycle ready goes to 1.
- Merge and overflow: din[2] pulses twice (0-1-0-1) before acceptance → exactly one id=2 event and ovf[2]=1. Pulsing ovf_clr → ovf=0. Repeat without the macro → one event, no ovf port.
- Re-arm: din[1] rise lands on the same edge its pending event is accepted → a second id=1 event is offered; ovf[1] stays 0.
- Reset mid-OFFER: resetn=0 for one edge while evt_valid=1 → evt_valid=0 and pending=0 after that edge. A din held high afterwards → one event after reset release.
